// File: rtl/apb_pwm_multi.sv
// Multi-channel APB PWM: one shared prescaler and period counter, per-channel
// double-buffered duty registers, wrap interrupt, zero-wait APB slave.
module apb_pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8
) (
  input  logic              pclk_i,
  input  logic              presetn_i,
  input  logic [31:0]       paddr_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  input  logic [3:0]        pstrb_i,
  output logic              pready_o,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq_o
);

  // APB: an access is psel & penable; pready is tied high, so every access
  // completes in that cycle and writes commit on the closing rising edge.
  logic              acc, err, wr_ok, w1c;
  logic [5:0]        widx, duty_off;
  logic              sel_ctrl, sel_pre, sel_per, sel_stat, sel_cnt, sel_duty;
  logic [31:0]       wmask, ctrl_rd, ctrl_new, rd_data;

  logic [NUM_CH-1:0] en_q;
  logic              irq_en_q, run_q, wrap_q, irq_q;
  logic [PRE_W-1:0]  pre_q, pre_cnt;
  logic [CNT_W-1:0]  per_q, per_sh, cnt_q;
  logic [CNT_W-1:0]  duty_q  [NUM_CH];
  logic [CNT_W-1:0]  duty_sh [NUM_CH];
  logic [NUM_CH-1:0] pwm_q;
  logic              tick, wrap_evt;
  logic              unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wdata,
                                        input logic [31:0] mask);
    return (old & ~mask) | (wdata & mask);
  endfunction

  assign acc      = psel_i & penable_i;
  assign widx     = paddr_i[7:2];
  assign duty_off = widx - 6'd8;
  assign sel_ctrl = (widx == 6'h00);
  assign sel_pre  = (widx == 6'h01);
  assign sel_per  = (widx == 6'h02);
  assign sel_stat = (widx == 6'h03);
  assign sel_cnt  = (widx == 6'h04);
  assign sel_duty = (widx >= 6'd8) && (duty_off < 6'(NUM_CH));

  assign err   = acc & ((paddr_i[1:0] != 2'b00)
                        | ~(sel_ctrl | sel_pre | sel_per | sel_stat | sel_cnt | sel_duty)
                        | (pwrite_i & sel_cnt));
  assign wr_ok = acc & pwrite_i & ~err;
  assign w1c   = wr_ok & sel_stat & pstrb_i[0] & pwdata_i[0];
  assign wmask = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}}, {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[NUM_CH-1:0] = en_q;
    ctrl_rd[30]         = irq_en_q;
    ctrl_rd[31]         = run_q;
  end
  assign ctrl_new = merge(ctrl_rd, pwdata_i, wmask);

  always_comb begin
    rd_data = '0;
    if (sel_ctrl) rd_data = ctrl_rd;
    if (sel_pre)  rd_data = 32'(pre_q);
    if (sel_per)  rd_data = 32'(per_q);
    if (sel_stat) rd_data = {31'b0, wrap_q};
    if (sel_cnt)  rd_data = 32'(cnt_q);
    for (int i = 0; i < NUM_CH; i++)
      if (sel_duty && (duty_off == 6'(i))) rd_data = 32'(duty_q[i]);
  end

  assign pready_o  = 1'b1;
  assign pslverr_o = err;
  assign prdata_o  = (acc & ~err) ? rd_data : '0;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      en_q     <= '0;
      irq_en_q <= 1'b0;
      run_q    <= 1'b0;
      pre_q    <= '0;
      per_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else if (wr_ok) begin
      if (sel_ctrl) begin
        en_q     <= ctrl_new[NUM_CH-1:0];
        irq_en_q <= ctrl_new[30];
        run_q    <= ctrl_new[31];
      end
      if (sel_pre) pre_q <= PRE_W'(merge(32'(pre_q), pwdata_i, wmask));
      if (sel_per) per_q <= CNT_W'(merge(32'(per_q), pwdata_i, wmask));
      for (int i = 0; i < NUM_CH; i++)
        if (sel_duty && (duty_off == 6'(i)))
          duty_q[i] <= CNT_W'(merge(32'(duty_q[i]), pwdata_i, wmask));
    end
  end

  // >= rather than == so a PRESCALE lowered mid-run cannot strand the prescaler.
  assign tick     = run_q & (pre_cnt >= pre_q);
  assign wrap_evt = tick & (cnt_q == per_sh);

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      pre_cnt <= '0;
      cnt_q   <= '0;
      per_sh  <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
      wrap_q  <= 1'b0;
      irq_q   <= 1'b0;
      pwm_q   <= '0;
    end else begin
      if (!run_q) begin
        pre_cnt <= '0;
        cnt_q   <= '0;
        per_sh  <= per_q;
        for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= duty_q[i];
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        if (wrap_evt) begin
          cnt_q  <= '0;
          per_sh <= per_q;
          for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= duty_q[i];
        end else if (tick) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      // A wrap in the same cycle as a W1C keeps WRAP set.
      if (wrap_evt)  wrap_q <= 1'b1;
      else if (w1c)  wrap_q <= 1'b0;
      irq_q <= wrap_q & irq_en_q;
      for (int i = 0; i < NUM_CH; i++)
        pwm_q[i] <= run_q & en_q[i] & (cnt_q < duty_sh[i]);
    end
  end

  assign pwm_o = pwm_q;
  assign irq_o = irq_q;

  assign unused_bits = &{1'b0, paddr_i[31:8], ctrl_new};

endmodule
